req_pending_scheduler: RTL and testbench
========================================

Name: req_pending_scheduler

Overview:
- Collects single-cycle request pulses from 32 channel sources into a pending register.
- Each cycle it selects one pending source, using a 32-to-5 priority encode where the highest index wins.
- Presents the selected 5-bit index on a registered valid/ready output with full throughput.
- Sits directly upstream of the channel service logic and is the stateful front end for the Merak channel index encoding.

Parameters:
- N, 32, number of request sources (fixed at 32; other values unsupported).
- IW, 5, index width, log2(N).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_in  input  32  request pulses; bit i high for one cycle means source i requests once.
- out_idx  output  5  selected source index; registered.
- out_valid  output  1  out_idx holds a valid selection; registered.
- out_ready  input  1  consumer accepts out_idx on a cycle where out_valid && out_ready.
- pending  output  32  current pending register; excludes the index held in the output register.
- overflow  output  1  one-cycle pulse: a request arrived for a source already pending, and the two merged.

Behaviour:
- Reset (rst high at a clk edge): pending=0, out_idx=0, out_valid=0, overflow=0, rr_ptr=31. Reset overrides every other input on that edge, including reset in the middle of a stall: the held index is dropped and is not re-queued.
- Output register "loads" on an edge when !out_valid || out_ready; otherwise it holds. out_idx and out_valid must be stable while out_valid && !out_ready.
- On a load:
  - if pending != 0: out_idx <= sel, out_valid <= 1, and pending bit sel is cleared on the same edge (the index is in flight);
  - if pending == 0: out_valid <= 0, out_idx holds its previous value.
- sel is the index of the highest set bit of pending, as a 5-bit binary value: bit 31 gives 5'd31, bit 0 gives 5'd0. In round-robin mode sel is computed as described in Optional Feature.
- Pending next state: pending_next = (pending & ~clear_mask) | req_in, where clear_mask is the one-hot sel bit on a load and 0 otherwise.
  - Set beats clear: if req_in[sel] is high on the load edge, bit sel stays pending.
- Re-request of the in-flight index is legal. It re-enters pending and does not pulse overflow.
- overflow <= |(req_in & pending) on every edge. Multiple merged bits in one cycle still produce a single pulse.
- Latency: req_in bit at edge t gives a pending bit after t. With the output register empty, out_valid goes high after edge t+1, i.e. 2 cycles from request to valid.
- Throughput: one index per cycle while out_ready is held high and pending is non-empty.
- No starvation guarantee in fixed-priority mode; a continuously re-requesting high index can lock out lower ones.

Optional Feature:
- Macro: REQ_PENDING_SCHEDULER_RR_EN.
- Defined: round-robin selection.
  - rr_ptr (5 bits) is updated to sel on every load with pending != 0.
  - masked = pending & {bits with index < rr_ptr}.
  - sel = highest set bit of masked if masked != 0, else highest set bit of pending (wrap-around).
  - rr_ptr resets to 31, so the first grant is the highest pending index.
- Undefined: rr_ptr is not implemented and selection is fixed priority, highest index first.
- Ports and latency are identical in both builds.

Test Plan:
- Reset, then idle 5 cycles -> out_valid=0, pending=0, overflow=0 throughout. Assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, pending=0.
- req_in=32'h8000_0001 for one cycle, out_ready=1 -> out_idx=31 on cycle t+2, out_idx=0 on t+3, out_valid=0 on t+4. Then idle.
- req_in=32'h0001_0000, out_ready=0 for 4 cycles -> out_idx=16 and out_valid=1 held stable, pending=0. Raise out_ready -> one acceptance, then out_valid=0.
- Pulse req_in bit 5 twice, 1 cycle apart, out_ready=0 with the output register already holding idx 9 -> overflow pulses once, and pending[5]=1 with a single entry.
- Re-request bit 9 while idx 9 is in flight -> no overflow; idx 9 delivered a second time after acceptance.
- RR_EN build: req_in=32'h0000_0111 held high continuously, out_ready=1 -> grant sequence 8,4,0,8,4,0. Non-RR build -> 8 every cycle.

Source files
------------

// File: rtl/req_pending_scheduler_if.sv
// Handshake bundle between the request sources, the scheduler and the
// downstream channel service logic.
// slave  : scheduler side (takes requests and ready, drives the selection)
// master : environment side (drives requests and ready, observes selection)
interface req_pending_scheduler_if;
    logic [31:0] req_in;
    logic [4:0]  out_idx;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pending;
    logic        overflow;

    modport slave (
        input  req_in,
        input  out_ready,
        output out_idx,
        output out_valid,
        output pending,
        output overflow
    );

    modport master (
        output req_in,
        output out_ready,
        input  out_idx,
        input  out_valid,
        input  pending,
        input  overflow
    );
endinterface

// File: rtl/req_pending_scheduler.sv
// req_pending_scheduler
// Gathers single-cycle request pulses from 32 sources into a pending set,
// and hands out one source index per cycle on a registered valid/ready output.
// Selection is the highest pending index. When REQ_PENDING_SCHEDULER_RR_EN is
// defined, selection rotates downward from the last granted index instead
// (round robin, wrapping to the highest pending index).
module req_pending_scheduler (
    input  logic                          clk,
    input  logic                          rst,
    req_pending_scheduler_if.slave        bus
);

    localparam int N  = 32;
    localparam int IW = 5;

    logic [N-1:0]  pending_q, pending_d;
    logic [IW-1:0] out_idx_q, out_idx_d;
    logic          out_valid_q, out_valid_d;
    logic          overflow_q, overflow_d;

    logic          load;
    logic          any_pending;
    logic [IW-1:0] sel;
    logic [N-1:0]  clear_mask;

    // Highest set bit of a 32-bit vector; 0 when the vector is empty.
    function automatic logic [IW-1:0] hi_idx(input logic [N-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) r = i[IW-1:0];
        end
        return r;
    endfunction

`ifdef REQ_PENDING_SCHEDULER_RR_EN
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [N-1:0]  below_ptr;
    logic [N-1:0]  masked;

    // Round-robin pick: highest pending index strictly below the last grant, else wrap.
    always_comb begin
        below_ptr = (32'd1 << rr_ptr_q) - 32'd1;
        masked    = pending_q & below_ptr;
        sel       = (masked != '0) ? hi_idx(masked) : hi_idx(pending_q);
        rr_ptr_d  = (load && any_pending) ? sel : rr_ptr_q;
    end
`else
    // Fixed priority pick: highest pending index wins.
    always_comb begin
        sel = hi_idx(pending_q);
    end
`endif

    // Next-state for the output register, pending set and overflow flag.
    always_comb begin
        any_pending = (pending_q != '0);
        load        = !out_valid_q || bus.out_ready;
        clear_mask  = '0;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        if (load) begin
            if (any_pending) begin
                out_idx_d   = sel;
                out_valid_d = 1'b1;
                clear_mask  = 32'd1 << sel;
            end else begin
                out_valid_d = 1'b0;
            end
        end
        // A new request on the selected bit survives the clear (set beats clear).
        pending_d  = (pending_q & ~clear_mask) | bus.req_in;
        // The in-flight index is no longer in pending_q, so re-requesting it is not a merge.
        overflow_d = |(bus.req_in & pending_q);
    end

    // State registers; reset drops any held index without re-queueing it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef REQ_PENDING_SCHEDULER_RR_EN
            rr_ptr_q    <= 5'd31;
`endif
        end else begin
            pending_q   <= pending_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
`ifdef REQ_PENDING_SCHEDULER_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign bus.out_idx   = out_idx_q;
    assign bus.out_valid = out_valid_q;
    assign bus.pending   = pending_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_req_pending_scheduler.sv
// Directed testbench for req_pending_scheduler (fixed-priority and round-robin builds).
module tb_req_pending_scheduler;

    logic clk;
    logic rst;
    int   tests;
    int   failed;

    req_pending_scheduler_if bus_if();

    req_pending_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs set afterwards are sampled on the next edge,
    // outputs read afterwards reflect the edge just taken.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_if.req_in = '0;
        bus_if.out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (bus_if.out_valid !== 1'b0 || bus_if.pending !== 32'h0 || bus_if.overflow !== 1'b0 || bus_if.out_idx !== 5'd0) begin
            failed++;
            $display("FAIL reset_state: valid=%b pending=%h ovf=%b idx=%0d, want 0/0/0/0",
                     bus_if.out_valid, bus_if.pending, bus_if.overflow, bus_if.out_idx);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (bus_if.out_valid !== 1'b0 || bus_if.pending !== 32'h0 || bus_if.overflow !== 1'b0) begin
                failed++;
                $display("FAIL idle_%0d: valid=%b pending=%h ovf=%b, want 0/0/0",
                         i, bus_if.out_valid, bus_if.pending, bus_if.overflow);
            end
        end
        // Reset while a stalled index is held.
        bus_if.req_in = 32'h0000_0008;
        tick();
        bus_if.req_in = '0;
        tick();
        tests++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_idx !== 5'd3) begin
            failed++;
            $display("FAIL stall_before_reset: valid=%b idx=%0d, want 1/3", bus_if.out_valid, bus_if.out_idx);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (bus_if.out_valid !== 1'b0 || bus_if.pending !== 32'h0 || bus_if.out_idx !== 5'd0) begin
            failed++;
            $display("FAIL reset_in_stall: valid=%b pending=%h idx=%0d, want 0/0/0",
                     bus_if.out_valid, bus_if.pending, bus_if.out_idx);
        end
        tick();
        tests++;
        if (bus_if.out_valid !== 1'b0 || bus_if.pending !== 32'h0) begin
            failed++;
            $display("FAIL reset_no_requeue: valid=%b pending=%h, want 0/0", bus_if.out_valid, bus_if.pending);
        end
    endtask

    task automatic test_two_ends();
        do_reset();
        bus_if.out_ready = 1'b1;
        bus_if.req_in = 32'h8000_0001;
        tick();
        bus_if.req_in = '0;
        tests++;
        if (bus_if.pending !== 32'h8000_0001 || bus_if.out_valid !== 1'b0) begin
            failed++;
            $display("FAIL two_ends_pending: pending=%h valid=%b, want 80000001/0", bus_if.pending, bus_if.out_valid);
        end
        tick();
        tests++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_idx !== 5'd31 || bus_if.pending !== 32'h0000_0001) begin
            failed++;
            $display("FAIL two_ends_first: valid=%b idx=%0d pending=%h, want 1/31/00000001",
                     bus_if.out_valid, bus_if.out_idx, bus_if.pending);
        end
        tick();
        tests++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_idx !== 5'd0 || bus_if.pending !== 32'h0) begin
            failed++;
            $display("FAIL two_ends_second: valid=%b idx=%0d pending=%h, want 1/0/0",
                     bus_if.out_valid, bus_if.out_idx, bus_if.pending);
        end
        tick();
        tests++;
        if (bus_if.out_valid !== 1'b0 || bus_if.out_idx !== 5'd0) begin
            failed++;
            $display("FAIL two_ends_drain: valid=%b idx=%0d, want 0/0", bus_if.out_valid, bus_if.out_idx);
        end
    endtask

    task automatic test_stall();
        do_reset();
        bus_if.req_in = 32'h0001_0000;
        tick();
        bus_if.req_in = '0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (bus_if.out_valid !== 1'b1 || bus_if.out_idx !== 5'd16 || bus_if.pending !== 32'h0) begin
                failed++;
                $display("FAIL stall_hold_%0d: valid=%b idx=%0d pending=%h, want 1/16/0",
                         i, bus_if.out_valid, bus_if.out_idx, bus_if.pending);
            end
            tick();
        end
        bus_if.out_ready = 1'b1;
        tick();
        tests++;
        if (bus_if.out_valid !== 1'b0) begin
            failed++;
            $display("FAIL stall_accept: valid=%b, want 0", bus_if.out_valid);
        end
        bus_if.out_ready = 1'b0;
    endtask

    task automatic test_overflow_and_rerequest();
        logic [4:0] first_idx;
        logic [4:0] second_idx;
        do_reset();
        bus_if.req_in = 32'h0000_0200;
        tick();
        bus_if.req_in = '0;
        tick();
        bus_if.req_in = 32'h0000_0020;
        tick();
        bus_if.req_in = '0;
        tests++;
        if (bus_if.overflow !== 1'b0 || bus_if.pending !== 32'h0000_0020) begin
            failed++;
            $display("FAIL ovf_first_req: ovf=%b pending=%h, want 0/00000020", bus_if.overflow, bus_if.pending);
        end
        tick();
        bus_if.req_in = 32'h0000_0020;
        tick();
        bus_if.req_in = '0;
        tests++;
        if (bus_if.overflow !== 1'b1 || bus_if.pending !== 32'h0000_0020) begin
            failed++;
            $display("FAIL ovf_merge: ovf=%b pending=%h, want 1/00000020", bus_if.overflow, bus_if.pending);
        end
        tick();
        tests++;
        if (bus_if.overflow !== 1'b0 || bus_if.out_idx !== 5'd9 || bus_if.out_valid !== 1'b1) begin
            failed++;
            $display("FAIL ovf_single_pulse: ovf=%b idx=%0d valid=%b, want 0/9/1",
                     bus_if.overflow, bus_if.out_idx, bus_if.out_valid);
        end
        // Re-request the in-flight index 9.
        bus_if.req_in = 32'h0000_0200;
        tick();
        bus_if.req_in = '0;
        tests++;
        if (bus_if.overflow !== 1'b0 || bus_if.pending !== 32'h0000_0220) begin
            failed++;
            $display("FAIL rereq_no_ovf: ovf=%b pending=%h, want 0/00000220", bus_if.overflow, bus_if.pending);
        end
`ifdef REQ_PENDING_SCHEDULER_RR_EN
        first_idx  = 5'd5;
        second_idx = 5'd9;
`else
        first_idx  = 5'd9;
        second_idx = 5'd5;
`endif
        bus_if.out_ready = 1'b1;
        tick();
        tests++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_idx !== first_idx) begin
            failed++;
            $display("FAIL rereq_grant_a: valid=%b idx=%0d, want 1/%0d", bus_if.out_valid, bus_if.out_idx, first_idx);
        end
        tick();
        tests++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_idx !== second_idx || bus_if.pending !== 32'h0) begin
            failed++;
            $display("FAIL rereq_grant_b: valid=%b idx=%0d pending=%h, want 1/%0d/0",
                     bus_if.out_valid, bus_if.out_idx, bus_if.pending, second_idx);
        end
        tick();
        tests++;
        if (bus_if.out_valid !== 1'b0) begin
            failed++;
            $display("FAIL rereq_drain: valid=%b, want 0", bus_if.out_valid);
        end
        bus_if.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_seq [6];
`ifdef REQ_PENDING_SCHEDULER_RR_EN
        exp_seq[0] = 5'd8; exp_seq[1] = 5'd4; exp_seq[2] = 5'd0;
        exp_seq[3] = 5'd8; exp_seq[4] = 5'd4; exp_seq[5] = 5'd0;
`else
        for (int i = 0; i < 6; i++) exp_seq[i] = 5'd8;
`endif
        do_reset();
        bus_if.out_ready = 1'b1;
        bus_if.req_in = 32'h0000_0111;
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if (bus_if.out_valid !== 1'b1 || bus_if.out_idx !== exp_seq[i]) begin
                failed++;
                $display("FAIL b2b_grant_%0d: valid=%b idx=%0d, want 1/%0d",
                         i, bus_if.out_valid, bus_if.out_idx, exp_seq[i]);
            end
        end
        bus_if.req_in = '0;
        bus_if.out_ready = 1'b0;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst = 1'b1;
        bus_if.req_in = '0;
        bus_if.out_ready = 1'b0;
        test_reset();
        test_two_ends();
        test_stall();
        test_overflow_and_rerequest();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
